bp_me_nonsynth_cache_req_driver: RTL and testbench
==================================================

# bp_me_nonsynth_cache_req_driver

Non-synthesizable test driver sitting directly upstream of the LCE under test. It accepts a stream of directed test commands, issues each as a single cache request on the LCE's cache request port, waits for completion, optionally checks returned load data, and records per-request latency. Its completion and traffic are what the LCE tracer observes; together they form the ME unit-test LCE harness.

## Interface
Parameters:
- bp_params_p, e_bp_test_multicore_half_cfg, processor config; supplies paddr_width_p, dword_width_gp.
- num_reqs_p, 0 (must be >0), commands to issue before done_o.
- issue_delay_p, 0, idle cycles inserted after each completion before the next issue.
- timeout_cycles_p, 4096, watchdog limit per request (used only with the watchdog macro).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- reset_i  in  1  synchronous, active-high reset.
- lce_id_i  in  lce_id_width_p  LCE id, used only in error messages.
- cmd_i  in  drv_cmd_width  packed bp_me_nonsynth_drv_cmd_s.
- cmd_v_i  in  1  command valid.
- cmd_ready_and_o  out  1  command accepted when cmd_v_i & cmd_ready_and_o.
- cache_req_o  out  cache_req_width  request header (op, addr, size, store data).
- cache_req_v_o  out  1  request valid.
- cache_req_ready_and_i  in  1  LCE accepts request.
- data_i  in  dword_width_gp  load return data.
- data_v_i  in  1  load return valid.
- cache_req_complete_i  in  1  cached miss/request complete pulse.
- uc_store_req_complete_i  in  1  uncached store complete pulse.
- done_o  out  1  num_reqs_p requests completed.
- error_o  out  1  sticky: data mismatch or timeout.
- mismatch_cnt_o  out  32  saturating count of failed checks.
- lat_max_o  out  32  largest observed request latency.

## Operation
- Command fields: op {load, store, uc_load, uc_store} 2b, addr paddr_width_p, size 2b (log2 bytes), data dword_width_gp, check 1b.
- FSM states: e_reset, e_ready, e_send, e_wait, e_delay, e_done.
- e_reset: one cycle after reset deasserts, then e_ready.
- e_ready: cmd_ready_and_o=1; on cmd handshake latch command into a single-entry register, go e_send.
- e_send: cache_req_v_o=1, request held stable until cache_req_ready_and_i; on handshake clear latency counter to 0, go e_wait.
- e_wait: latency counter increments every cycle, saturating at 2^32-1. Completion: load/uc_load when data_v_i; store when cache_req_complete_i; uc_store when uc_store_req_complete_i. Completion pulses arriving outside e_wait are ignored and $error'd.
- On load completion with check=1: compare data_i against latched data masked to 8·2^size low bits; on mismatch set error_o, increment mismatch_cnt_o (saturating), $error with lce_id_i and addr.
- On completion: lat_max_o = max(lat_max_o, counter+1); increment issued count; if count reaches num_reqs_p go e_done, else e_delay (or e_ready when issue_delay_p=0).
- e_delay: down-counter from issue_delay_p to 0, then e_ready.
- e_done: done_o=1, all ready/valid outputs 0; terminal until reset.

## Timing
- Reset values: cmd_ready_and_o=0, cache_req_v_o=0, cache_req_o=0, done_o=0, error_o=0, mismatch_cnt_o=0, lat_max_o=0.
- Command accepted in cycle N → cache_req_v_o high in N+1 (one-cycle latency).
- Latency = cycles from request handshake (exclusive) to completion cycle (inclusive); same-cycle completion impossible.
- Completion in cycle M with issue_delay_p=D → cmd_ready_and_o high in M+1+D.
- Simultaneous data_v_i and cache_req_complete_i during a load: data_v_i is the completion; the other is ignored.
- Reset asserted mid-transaction: FSM to e_reset next cycle, all counters and sticky outputs cleared, no partial statistics retained.
- Only one request outstanding ever.

## Configuration
- BP_ME_NONSYNTH_DRV_WATCHDOG_EN defined: per-request cycle counter in e_wait; on reaching timeout_cycles_p set error_o, $error with addr, go e_done.
- Undefined: no watchdog; e_wait waits indefinitely; timeout_cycles_p unused.

## Structure
- bp_me_nonsynth_pkg: drv op enum, bp_me_nonsynth_drv_cmd_s, FSM state enum.
- Latency counter is the one sub-module: bsg_counter_clear_up (max_val_p 2^32-1), clear on request handshake, up in e_wait.

## Test plan
- Single load addr 0x8000_0040, check=1, data 0xDEAD_BEEF, LCE returns same after 5 cycles → done_o=1, error_o=0, lat_max_o=5.
- Load with check=1 returning 0x0 vs expected 0x1234 → error_o=1, mismatch_cnt_o=1.
- size=0 load expected 0xAB, data_i 0xFFFF_FFAB → no mismatch (masked).
- Two stores, cache_req_ready_and_i stalled 3 cycles, issue_delay_p=2 → cache_req_o stable during stall; second cmd_ready_and_o exactly 3 cycles after first completion.
- Reset in e_wait → next cycle all outputs at reset values; fresh run completes normally.
- Watchdog build, timeout_cycles_p=16, no completion → error_o set on 16th wait cycle, FSM in e_done.

Source files
------------

// File: rtl/bp_me_nonsynth_pkg.sv
// Shared types for the ME unit-test cache request driver: command/request
// layouts, driver FSM states and small helpers.
package bp_me_nonsynth_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_test_multicore_half_cfg
    } bp_params_e;

    localparam int paddr_width_gp = 40;
    localparam int dword_width_gp = 64;

    function automatic int lce_id_width_f(bp_params_e cfg);
        return (cfg == e_bp_test_multicore_half_cfg) ? 2 : 1;
    endfunction

    typedef enum logic [1:0] {
        e_drv_load,
        e_drv_store,
        e_drv_uc_load,
        e_drv_uc_store
    } bp_me_nonsynth_drv_op_e;

    typedef struct packed {
        bp_me_nonsynth_drv_op_e    op;
        logic [paddr_width_gp-1:0] addr;
        logic [1:0]                size;
        logic [dword_width_gp-1:0] data;
        logic                      check;
    } bp_me_nonsynth_drv_cmd_s;

    typedef struct packed {
        bp_me_nonsynth_drv_op_e    op;
        logic [paddr_width_gp-1:0] addr;
        logic [1:0]                size;
        logic [dword_width_gp-1:0] data;
    } bp_me_nonsynth_cache_req_s;

    localparam int drv_cmd_width_gp   = $bits(bp_me_nonsynth_drv_cmd_s);
    localparam int cache_req_width_gp = $bits(bp_me_nonsynth_cache_req_s);

    typedef enum logic [2:0] {
        e_reset,
        e_ready,
        e_send,
        e_wait,
        e_delay,
        e_done
    } drv_state_e;

    // Low 8*2^size bits of a dword are significant for a load of that size.
    function automatic logic [dword_width_gp-1:0] size_mask_f(logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up-counter with synchronous clear that saturates at max_val_p.
module bsg_counter_clear_up #(
    parameter int                 width_p   = 32,
    parameter logic [width_p-1:0] max_val_p = '1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (up_i && (count_q != max_val_p))
            count_d = count_q + width_p'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_me_nonsynth_cache_req_driver.sv
// Issues directed commands one at a time to the LCE, checks load data and
// tracks worst-case latency. Define BP_ME_NONSYNTH_DRV_WATCHDOG_EN for a per-request timeout.
//   state   | meaning
//   e_reset | one settle cycle after reset
//   e_ready | accepting the next command
//   e_send  | request valid, held until LCE accepts
//   e_wait  | request outstanding, latency counting
//   e_delay | idle gap before next issue
//   e_done  | all requests completed (or timed out)
module bp_me_nonsynth_cache_req_driver
    import bp_me_nonsynth_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_test_multicore_half_cfg,
    parameter int         num_reqs_p       = 0,
    parameter int         issue_delay_p    = 0,
    parameter int         timeout_cycles_p = 4096,
    parameter bit         err_report_p     = 1'b1,
    localparam int        lce_id_width_p   = lce_id_width_f(bp_params_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [lce_id_width_p-1:0]     lce_id_i,
    input  logic [drv_cmd_width_gp-1:0]   cmd_i,
    input  logic                          cmd_v_i,
    output logic                          cmd_ready_and_o,
    output logic [cache_req_width_gp-1:0] cache_req_o,
    output logic                          cache_req_v_o,
    input  logic                          cache_req_ready_and_i,
    input  logic [dword_width_gp-1:0]     data_i,
    input  logic                          data_v_i,
    input  logic                          cache_req_complete_i,
    input  logic                          uc_store_req_complete_i,
    output logic                          done_o,
    output logic                          error_o,
    output logic [31:0]                   mismatch_cnt_o,
    output logic [31:0]                   lat_max_o
);

    localparam logic [31:0] num_reqs_lp   = 32'(num_reqs_p);
    localparam logic [31:0] delay_init_lp = (issue_delay_p > 0) ? 32'(issue_delay_p - 1) : 32'd0;

    drv_state_e              state_q, state_d;
    bp_me_nonsynth_drv_cmd_s cmd_q, cmd_d;
    bp_me_nonsynth_cache_req_s req;
    logic [31:0] req_cnt_q, req_cnt_d, delay_q, delay_d;
    logic [31:0] mis_q, mis_d, lat_max_q, lat_max_d;
    logic        err_q, err_d;
    logic [31:0] lat_cnt, lat_sample;
    logic        lat_clear, lat_up, is_load, req_done, data_bad, any_done_pulse, timeout;

    assign lat_clear = (state_q == e_send) && cache_req_ready_and_i;
    assign lat_up    = (state_q == e_wait);

    bsg_counter_clear_up #(
        .width_p   (32),
        .max_val_p (32'hFFFF_FFFF)
    ) lat_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (lat_clear),
        .up_i    (lat_up),
        .count_o (lat_cnt)
    );

    assign is_load        = (cmd_q.op == e_drv_load) || (cmd_q.op == e_drv_uc_load);
    assign data_bad       = is_load && cmd_q.check
                            && (((data_i ^ cmd_q.data) & size_mask_f(cmd_q.size)) != '0);
    assign lat_sample     = (lat_cnt == 32'hFFFF_FFFF) ? lat_cnt : lat_cnt + 32'd1;
    assign any_done_pulse = data_v_i | cache_req_complete_i | uc_store_req_complete_i;

    // Only the pulse matching the outstanding op counts as its completion.
    always_comb begin
        req_done = 1'b0;
        case (cmd_q.op)
            e_drv_load, e_drv_uc_load: req_done = data_v_i;
            e_drv_store:               req_done = cache_req_complete_i;
            default:                   req_done = uc_store_req_complete_i;
        endcase
    end

`ifdef BP_ME_NONSYNTH_DRV_WATCHDOG_EN
    localparam logic [31:0] wdog_init_lp = (timeout_cycles_p > 0) ? 32'(timeout_cycles_p - 1) : 32'd0;
    logic [31:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = wdog_q;
        if (lat_clear)
            wdog_d = wdog_init_lp;
        else if ((state_q == e_wait) && (wdog_q != '0))
            wdog_d = wdog_q - 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            wdog_q <= '0;
        else
            wdog_q <= wdog_d;
    end

    assign timeout = (state_q == e_wait) && !req_done && (wdog_q == '0);
`else
    localparam int unused_timeout_lp = timeout_cycles_p;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        req_cnt_d       = req_cnt_q;
        delay_d         = delay_q;
        mis_d           = mis_q;
        lat_max_d       = lat_max_q;
        err_d           = err_q;
        cmd_ready_and_o = 1'b0;
        cache_req_v_o   = 1'b0;
        done_o          = 1'b0;
        case (state_q)
            e_reset: state_d = e_ready;
            e_ready: begin
                cmd_ready_and_o = 1'b1;
                if (cmd_v_i) begin
                    cmd_d   = bp_me_nonsynth_drv_cmd_s'(cmd_i);
                    state_d = e_send;
                end
            end
            e_send: begin
                cache_req_v_o = 1'b1;
                if (cache_req_ready_and_i)
                    state_d = e_wait;
            end
            e_wait: begin
                if (req_done) begin
                    if (data_bad) begin
                        err_d = 1'b1;
                        if (mis_q != 32'hFFFF_FFFF)
                            mis_d = mis_q + 32'd1;
                    end
                    if (lat_sample > lat_max_q)
                        lat_max_d = lat_sample;
                    req_cnt_d = req_cnt_q + 32'd1;
                    if (req_cnt_d == num_reqs_lp)
                        state_d = e_done;
                    else if (issue_delay_p > 0) begin
                        state_d = e_delay;
                        delay_d = delay_init_lp;
                    end else
                        state_d = e_ready;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = e_done;
                end
            end
            e_delay: begin
                if (delay_q == '0)
                    state_d = e_ready;
                else
                    delay_d = delay_q - 32'd1;
            end
            e_done:  done_o = 1'b1;
            default: state_d = e_reset;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_reset;
            cmd_q     <= '0;
            req_cnt_q <= '0;
            delay_q   <= '0;
            mis_q     <= '0;
            lat_max_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            req_cnt_q <= req_cnt_d;
            delay_q   <= delay_d;
            mis_q     <= mis_d;
            lat_max_q <= lat_max_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && err_report_p) begin
            if ((state_q == e_wait) && req_done && data_bad)
                $error("lce %0d: load data mismatch at addr %h", lce_id_i, cmd_q.addr);
            if ((state_q != e_wait) && any_done_pulse)
                $error("lce %0d: completion pulse with no request outstanding", lce_id_i);
            if (timeout)
                $error("lce %0d: request timeout at addr %h", lce_id_i, cmd_q.addr);
        end
    end

    assign req            = '{op: cmd_q.op, addr: cmd_q.addr, size: cmd_q.size, data: cmd_q.data};
    assign cache_req_o    = req;
    assign error_o        = err_q;
    assign mismatch_cnt_o = mis_q;
    assign lat_max_o      = lat_max_q;

endmodule

// File: tb/tb_bp_me_nonsynth_cache_req_driver.sv
// Scoreboard bench for the cache request driver (two requests per run, 2-cycle issue gap).
module tb_bp_me_nonsynth_cache_req_driver;
    import bp_me_nonsynth_pkg::*;

    localparam int lce_w = lce_id_width_f(e_bp_test_multicore_half_cfg);

    logic                          clk_i = 1'b0;
    logic                          reset_i;
    logic [lce_w-1:0]              lce_id_i;
    logic [drv_cmd_width_gp-1:0]   cmd_i;
    logic                          cmd_v_i;
    logic                          cmd_ready_and_o;
    logic [cache_req_width_gp-1:0] cache_req_o;
    logic                          cache_req_v_o;
    logic                          cache_req_ready_and_i;
    logic [dword_width_gp-1:0]     data_i;
    logic                          data_v_i;
    logic                          cache_req_complete_i;
    logic                          uc_store_req_complete_i;
    logic                          done_o;
    logic                          error_o;
    logic [31:0]                   mismatch_cnt_o;
    logic [31:0]                   lat_max_o;

    bp_me_nonsynth_cache_req_driver #(
        .bp_params_p      (e_bp_test_multicore_half_cfg),
        .num_reqs_p       (2),
        .issue_delay_p    (2),
        .timeout_cycles_p (16),
        .err_report_p     (1'b0)
    ) dut (
        .clk_i                   (clk_i),
        .reset_i                 (reset_i),
        .lce_id_i                (lce_id_i),
        .cmd_i                   (cmd_i),
        .cmd_v_i                 (cmd_v_i),
        .cmd_ready_and_o         (cmd_ready_and_o),
        .cache_req_o             (cache_req_o),
        .cache_req_v_o           (cache_req_v_o),
        .cache_req_ready_and_i   (cache_req_ready_and_i),
        .data_i                  (data_i),
        .data_v_i                (data_v_i),
        .cache_req_complete_i    (cache_req_complete_i),
        .uc_store_req_complete_i (uc_store_req_complete_i),
        .done_o                  (done_o),
        .error_o                 (error_o),
        .mismatch_cnt_o          (mismatch_cnt_o),
        .lat_max_o               (lat_max_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    bp_me_nonsynth_cache_req_s exp_q[$];
    bit          exp_err;
    logic [31:0] exp_mis;
    logic [31:0] exp_lat_max;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit bytes_differ(logic [1:0] size, logic [63:0] a, logic [63:0] b);
        for (int i = 0; i < (1 << size); i++)
            if (a[i*8 +: 8] !== b[i*8 +: 8]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset_i = 1'b1;
        cmd_v_i = 1'b0; cmd_i = '0; cache_req_ready_and_i = 1'b0;
        data_i = '0; data_v_i = 1'b0; cache_req_complete_i = 1'b0; uc_store_req_complete_i = 1'b0;
        step(); step();
        exp_q.delete(); exp_err = 1'b0; exp_mis = '0; exp_lat_max = '0;
        reset_i = 1'b0;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (cmd_ready_and_o !== 1'b1 && guard < 50) begin step(); guard++; end
        tests++;
        if (cmd_ready_and_o !== 1'b1) begin
            fails++; $display("FAIL cmd_ready_wait: cmd_ready_and_o=%b required 1", cmd_ready_and_o);
        end
    endtask

    // Drive one command through handshake, stall, latency and completion.
    task automatic issue(input bp_me_nonsynth_drv_op_e a_op, input logic [39:0] a_addr,
                         input logic [1:0] a_size, input logic [63:0] a_data, input bit a_check,
                         input int stall, input int lat, input logic [63:0] ret, input bit extra);
        bp_me_nonsynth_drv_cmd_s   c;
        bp_me_nonsynth_cache_req_s r;
        wait_ready();
        c = '{op: a_op, addr: a_addr, size: a_size, data: a_data, check: a_check};
        cmd_i = c; cmd_v_i = 1'b1;
        exp_q.push_back('{op: a_op, addr: a_addr, size: a_size, data: a_data});
        step();
        cmd_v_i = 1'b0; cmd_i = '0;
        tests++;
        if (cache_req_v_o !== 1'b1) begin
            fails++; $display("FAIL req_v_latency: cache_req_v_o=%b required 1", cache_req_v_o);
        end
        for (int i = 0; i < stall; i++) begin
            tests++;
            if (cache_req_o !== exp_q[0] || cache_req_v_o !== 1'b1) begin
                fails++; $display("FAIL req_stall: req=%h v=%b required %h v=1", cache_req_o, cache_req_v_o, exp_q[0]);
            end
            step();
        end
        cache_req_ready_and_i = 1'b1;
        r = exp_q.pop_front();
        tests++;
        if (cache_req_o !== r) begin
            fails++; $display("FAIL req_hdr: got %h required %h", cache_req_o, r);
        end
        step();
        cache_req_ready_and_i = 1'b0;
        tests++;
        if (cache_req_v_o !== 1'b0) begin
            fails++; $display("FAIL req_v_drop: cache_req_v_o=%b required 0", cache_req_v_o);
        end
        for (int i = 1; i < lat; i++) begin
            if (extra && i == 1) cache_req_complete_i = 1'b1;
            step();
            cache_req_complete_i = 1'b0;
        end
        case (a_op)
            e_drv_load, e_drv_uc_load: begin
                data_v_i = 1'b1; data_i = ret;
                if (extra) cache_req_complete_i = 1'b1;
            end
            e_drv_store: cache_req_complete_i = 1'b1;
            default:     uc_store_req_complete_i = 1'b1;
        endcase
        step();
        data_v_i = 1'b0; data_i = '0; cache_req_complete_i = 1'b0; uc_store_req_complete_i = 1'b0;
        if ((a_op == e_drv_load || a_op == e_drv_uc_load) && a_check && bytes_differ(a_size, a_data, ret)) begin
            exp_err = 1'b1;
            exp_mis = exp_mis + 32'd1;
        end
        if (32'(lat) > exp_lat_max) exp_lat_max = 32'(lat);
    endtask

    task automatic start_req(input logic [39:0] a_addr);
        bp_me_nonsynth_drv_cmd_s c;
        wait_ready();
        c = '{op: e_drv_load, addr: a_addr, size: 2'd3, data: 64'h0, check: 1'b0};
        cmd_i = c; cmd_v_i = 1'b1;
        step();
        cmd_v_i = 1'b0; cmd_i = '0; cache_req_ready_and_i = 1'b1;
        step();
        cache_req_ready_and_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        cmd_v_i = 1'b0; cmd_i = '0; cache_req_ready_and_i = 1'b0;
        data_i = '0; data_v_i = 1'b0; cache_req_complete_i = 1'b0; uc_store_req_complete_i = 1'b0;
        step(); step();
        tests++;
        if ({cmd_ready_and_o, cache_req_v_o, done_o, error_o} !== 4'b0000 || cache_req_o !== '0
            || mismatch_cnt_o !== 32'd0 || lat_max_o !== 32'd0) begin
            fails++; $display("FAIL reset_vals: rdy=%b v=%b done=%b err=%b req=%h mis=%0d lat=%0d required all 0",
                              cmd_ready_and_o, cache_req_v_o, done_o, error_o, cache_req_o, mismatch_cnt_o, lat_max_o);
        end
        reset_i = 1'b0;
        tests++;
        if (cmd_ready_and_o !== 1'b0) begin
            fails++; $display("FAIL reset_settle: cmd_ready_and_o=%b required 0", cmd_ready_and_o);
        end
        step();
        tests++;
        if (cmd_ready_and_o !== 1'b1) begin
            fails++; $display("FAIL reset_ready: cmd_ready_and_o=%b required 1", cmd_ready_and_o);
        end
    endtask

    task automatic test_load_check();
        do_reset();
        issue(e_drv_load, 40'h00_8000_0040, 2'd3, 64'hDEAD_BEEF, 1'b1, 0, 5, 64'hDEAD_BEEF, 1'b0);
        issue(e_drv_store, 40'h00_8000_0080, 2'd3, 64'h1111, 1'b0, 0, 2, 64'h0, 1'b0);
        tests++;
        if (done_o !== 1'b1 || error_o !== exp_err || lat_max_o !== exp_lat_max
            || cmd_ready_and_o !== 1'b0 || cache_req_v_o !== 1'b0) begin
            fails++; $display("FAIL load_done: done=%b err=%b lat=%0d rdy=%b v=%b required 1 %b %0d 0 0",
                              done_o, error_o, lat_max_o, cmd_ready_and_o, cache_req_v_o, exp_err, exp_lat_max);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        issue(e_drv_load, 40'h00_8000_0300, 2'd3, 64'h1234, 1'b1, 0, 2, 64'h0, 1'b0);
        tests++;
        if (error_o !== exp_err || mismatch_cnt_o !== exp_mis) begin
            fails++; $display("FAIL mismatch_flag: err=%b mis=%0d required %b %0d", error_o, mismatch_cnt_o, exp_err, exp_mis);
        end
        issue(e_drv_load, 40'h00_8000_0308, 2'd3, 64'h77, 1'b1, 0, 3, 64'h77, 1'b1);
        tests++;
        if (done_o !== 1'b1 || mismatch_cnt_o !== exp_mis || lat_max_o !== exp_lat_max) begin
            fails++; $display("FAIL simultaneous_pulse: done=%b mis=%0d lat=%0d required 1 %0d %0d",
                              done_o, mismatch_cnt_o, lat_max_o, exp_mis, exp_lat_max);
        end
    endtask

    task automatic test_size_mask();
        do_reset();
        issue(e_drv_load, 40'h00_8000_0400, 2'd0, 64'hAB, 1'b1, 0, 1, 64'hFFFF_FFAB, 1'b0);
        tests++;
        if (error_o !== exp_err || mismatch_cnt_o !== exp_mis) begin
            fails++; $display("FAIL size0_mask: err=%b mis=%0d required %b %0d", error_o, mismatch_cnt_o, exp_err, exp_mis);
        end
        issue(e_drv_load, 40'h00_8000_0402, 2'd1, 64'h12AB, 1'b1, 0, 2, 64'hFFFF_00AB, 1'b0);
        tests++;
        if (error_o !== exp_err || mismatch_cnt_o !== exp_mis) begin
            fails++; $display("FAIL size1_mask: err=%b mis=%0d required %b %0d", error_o, mismatch_cnt_o, exp_err, exp_mis);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(e_drv_store, 40'h00_8000_0200, 2'd3, 64'h55, 1'b0, 3, 4, 64'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (cmd_ready_and_o !== 1'b0) begin
                fails++; $display("FAIL delay_gap%0d: cmd_ready_and_o=%b required 0", i, cmd_ready_and_o);
            end
            step();
        end
        tests++;
        if (cmd_ready_and_o !== 1'b1) begin
            fails++; $display("FAIL delay_ready: cmd_ready_and_o=%b required 1", cmd_ready_and_o);
        end
        issue(e_drv_uc_store, 40'h00_8000_0208, 2'd2, 64'h66, 1'b0, 1, 1, 64'h0, 1'b0);
        data_v_i = 1'b1;
        step();
        data_v_i = 1'b0;
        tests++;
        if (done_o !== 1'b1 || error_o !== 1'b0 || lat_max_o !== exp_lat_max) begin
            fails++; $display("FAIL store_done: done=%b err=%b lat=%0d required 1 0 %0d", done_o, error_o, lat_max_o, exp_lat_max);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(e_drv_load, 40'h00_8000_0500, 2'd3, 64'h1234, 1'b1, 0, 3, 64'h0, 1'b0);
        tests++;
        if (error_o !== 1'b1 || lat_max_o !== 32'd3) begin
            fails++; $display("FAIL pre_reset_stats: err=%b lat=%0d required 1 3", error_o, lat_max_o);
        end
        start_req(40'h00_8000_0508);
        step(); step();
        reset_i = 1'b1;
        step();
        tests++;
        if ({cmd_ready_and_o, cache_req_v_o, done_o, error_o} !== 4'b0000 || cache_req_o !== '0
            || mismatch_cnt_o !== 32'd0 || lat_max_o !== 32'd0) begin
            fails++; $display("FAIL mid_reset_vals: rdy=%b v=%b done=%b err=%b req=%h mis=%0d lat=%0d required all 0",
                              cmd_ready_and_o, cache_req_v_o, done_o, error_o, cache_req_o, mismatch_cnt_o, lat_max_o);
        end
        do_reset();
        issue(e_drv_uc_load, 40'h00_8000_0600, 2'd2, 64'hCAFE_F00D, 1'b1, 2, 2, 64'h9999_CAFE_F00D, 1'b0);
        issue(e_drv_load, 40'h00_8000_0640, 2'd3, 64'h42, 1'b1, 0, 4, 64'h42, 1'b0);
        tests++;
        if (done_o !== 1'b1 || error_o !== 1'b0 || mismatch_cnt_o !== 32'd0 || lat_max_o !== exp_lat_max) begin
            fails++; $display("FAIL fresh_run: done=%b err=%b mis=%0d lat=%0d required 1 0 0 %0d",
                              done_o, error_o, mismatch_cnt_o, lat_max_o, exp_lat_max);
        end
    endtask

`ifdef BP_ME_NONSYNTH_DRV_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        start_req(40'h00_8000_0700);
        for (int i = 1; i < 16; i++) step();
        tests++;
        if (error_o !== 1'b0 || done_o !== 1'b0) begin
            fails++; $display("FAIL wdog_early: err=%b done=%b required 0 0", error_o, done_o);
        end
        step();
        tests++;
        if (error_o !== 1'b1 || done_o !== 1'b1) begin
            fails++; $display("FAIL wdog_fire: err=%b done=%b required 1 1", error_o, done_o);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        lce_id_i = lce_w'(1);
        test_reset();
        test_load_check();
        test_mismatch();
        test_size_mask();
        test_back_to_back();
        test_reset_mid();
`ifdef BP_ME_NONSYNTH_DRV_WATCHDOG_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
